// File: rtl/vss_pkg.sv
// Shared types and constants for the 20b-to-10b video serializer.
// VSS_UNDERRUN_BLANK_EN (see top) selects the blanking behaviour of IDLE.
package vss_pkg;

  localparam int VSS_HALF_W = 10;

  localparam logic [VSS_HALF_W-1:0] VSS_BLANK_C = 10'h200;
  localparam logic [VSS_HALF_W-1:0] VSS_BLANK_Y = 10'h040;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } vss_state_t;

  typedef struct packed {
    logic [2*VSS_HALF_W-1:0] word;
    logic                    hsync;
    logic                    vsync;
    logic                    fsync;
  } vss_entry_t;

  // Occupancy after an edge; callers never push when full or pop when empty.
  function automatic logic [1:0] vss_count_next(input logic [1:0] count,
                                                input logic       push,
                                                input logic       pop);
    logic [1:0] v_next;
    v_next = count;
    if (push && !pop) begin
      v_next = count + 2'd1;
    end else if (pop && !push) begin
      v_next = count - 2'd1;
    end else begin
      v_next = count;
    end
    return v_next;
  endfunction

endpackage

// File: rtl/vss_fifo2.sv
// Two-entry FIFO of word+sync entries with synchronous active-high reset.
// Pushes while full and pops while empty are ignored.
module vss_fifo2
  import vss_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  vss_entry_t i_push_data,
  input  logic       i_pop,
  output vss_entry_t o_pop_data,
  output logic [1:0] o_count,
  output logic       o_full,
  output logic       o_empty
);

  vss_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push_ok;
  logic       w_pop_ok;

  // Qualify requests against current occupancy
  always_comb begin
    w_push_ok = i_push && (r_count != 2'd2);
    w_pop_ok  = i_pop && (r_count != 2'd0);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= vss_count_next(r_count, w_push_ok, w_pop_ok);
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = (r_count == 2'd2);
  assign o_empty    = (r_count == 2'd0);

endmodule

// File: rtl/video_ser_20b_to_10b.sv
// Serializes packed 2-sample video words into one sample per clock, low half first.
// Define VSS_UNDERRUN_BLANK_EN to emit C/Y blanking codes while idle after data.
module video_ser_20b_to_10b
  import vss_pkg::*;
#(
  parameter int HALF_W = VSS_HALF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*HALF_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              fsync_in,
  output logic [HALF_W-1:0] data_out,
  output logic              out_valid,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              fsync_out,
  output logic              phase,
  output logic              underrun
);

  vss_entry_t        w_push_entry;
  vss_entry_t        w_pop_entry;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic [1:0]        w_count_next;

  vss_state_t        r_state;
  logic [HALF_W-1:0] r_high;
  logic [HALF_W-1:0] r_data_out;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_fsync;
  logic              r_phase;
  logic              r_underrun;
  logic              r_emitted;

  // Handshake and pop decision; a pop only happens where a new word may start
  always_comb begin
    w_push_entry.word  = data_in;
    w_push_entry.hsync = hsync_in;
    w_push_entry.vsync = vsync_in;
    w_push_entry.fsync = fsync_in;
    w_push             = in_valid && r_in_ready && !w_fifo_full;
    w_pop              = !w_fifo_empty && (r_state != ST_LOW);
    w_count_next       = vss_count_next(w_fifo_count, w_push, w_pop);
  end

  vss_fifo2 u_fifo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_entry),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  // Serializer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_high      <= '0;
      r_data_out  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_fsync     <= 1'b0;
      r_phase     <= 1'b0;
      r_underrun  <= 1'b0;
      r_emitted   <= 1'b0;
    end else begin
      r_in_ready <= (w_count_next != 2'd2);
      case (r_state)
        ST_IDLE, ST_HIGH: begin
          if (w_pop) begin
            r_state     <= ST_LOW;
            r_data_out  <= w_pop_entry.word[HALF_W-1:0];
            r_high      <= w_pop_entry.word[2*HALF_W-1:HALF_W];
            r_hsync     <= w_pop_entry.hsync;
            r_vsync     <= w_pop_entry.vsync;
            r_fsync     <= w_pop_entry.fsync;
            r_phase     <= 1'b0;
            r_out_valid <= 1'b1;
            r_emitted   <= 1'b1;
          end else if (r_state == ST_HIGH) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_phase     <= 1'b0;
            r_underrun  <= r_underrun | r_emitted;
`ifdef VSS_UNDERRUN_BLANK_EN
            r_data_out  <= VSS_BLANK_C;
`endif
          end else begin
            r_out_valid <= 1'b0;
`ifdef VSS_UNDERRUN_BLANK_EN
            // Blanking alternates only once real data has been sent
            if (r_emitted) begin
              r_data_out <= r_phase ? VSS_BLANK_C : VSS_BLANK_Y;
              r_phase    <= ~r_phase;
            end
`endif
          end
        end
        ST_LOW: begin
          r_state    <= ST_HIGH;
          r_data_out <= r_high;
          r_phase    <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_phase     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign hsync_out = r_hsync;
  assign vsync_out = r_vsync;
  assign fsync_out = r_fsync;
  assign phase     = r_phase;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_video_ser_20b_to_10b.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed literal checks for reset, latency, streaming, sync alignment and reset mid-word.
`timescale 1ns/1ps
module tb_video_ser_20b_to_10b;

  localparam int HW = 10;
  localparam logic [HW-1:0] BLANK_C = 10'h200;
  localparam logic [HW-1:0] BLANK_Y = 10'h040;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*HW-1:0] data_in = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            hsync_in = 1'b0;
  logic            vsync_in = 1'b0;
  logic            fsync_in = 1'b0;
  logic [HW-1:0]   data_out;
  logic            out_valid;
  logic            hsync_out;
  logic            vsync_out;
  logic            fsync_out;
  logic            phase;
  logic            underrun;

  always #5 clk = ~clk;

  video_ser_20b_to_10b #(.HALF_W(HW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .fsync_in  (fsync_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .fsync_out (fsync_out),
    .phase     (phase),
    .underrun  (underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2*HW-1:0] w;
    logic h;
    logic v;
    logic f;
  } ent_t;

  ent_t          q[$];
  ent_t          cur;
  int            stage = 0;   // 0: nothing shown, 1: low half shown, 2: high half shown
  bit            live = 1'b0;
  bit            emitted = 1'b0;
  logic [HW-1:0] e_data = '0;
  logic          e_valid = 1'b0, e_phase = 1'b0, e_ready = 1'b0, e_under = 1'b0;
  logic          e_h = 1'b0, e_v = 1'b0, e_f = 1'b0;

  always @(posedge clk) begin
    bit take;
    if (rst) begin
      q.delete();
      stage = 0; emitted = 1'b0;
      e_data = '0; e_valid = 1'b0; e_phase = 1'b0; e_ready = 1'b0; e_under = 1'b0;
      e_h = 1'b0; e_v = 1'b0; e_f = 1'b0;
    end else begin
      take = in_valid && e_ready;
      if (stage == 1) begin
        stage = 2;
        e_data = cur.w[2*HW-1:HW];
        e_phase = 1'b1;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
        stage = 1;
        emitted = 1'b1;
        e_data = cur.w[HW-1:0];
        e_phase = 1'b0; e_valid = 1'b1;
        e_h = cur.h; e_v = cur.v; e_f = cur.f;
      end else begin
        e_valid = 1'b0;
        if (stage == 2) begin
          e_under = 1'b1;
          e_phase = 1'b0;
`ifdef VSS_UNDERRUN_BLANK_EN
          e_data = BLANK_C;
        end else if (emitted) begin
          e_data = e_phase ? BLANK_C : BLANK_Y;
          e_phase = ~e_phase;
`endif
        end
        stage = 0;
      end
      if (take) q.push_back('{w: data_in, h: hsync_in, v: vsync_in, f: fsync_in});
      e_ready = (q.size() < 2);
    end
    live = 1'b1;
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (live) begin
      check("m_data_out",  data_out,  e_data);
      check("m_out_valid", out_valid, e_valid);
      check("m_phase",     phase,     e_phase);
      check("m_in_ready",  in_ready,  e_ready);
      check("m_underrun",  underrun,  e_under);
      check("m_hsync",     hsync_out, e_h);
      check("m_vsync",     vsync_out, e_v);
      check("m_fsync",     fsync_out, e_f);
    end
  end

  // ---------------- directed stimulus ----------------
  int run = 0, max_run = 0, hs_cnt = 0;
  bit rdy_low_seen = 1'b0;

  task automatic cycle();
    @(negedge clk);
    if (out_valid) run++; else run = 0;
    if (run > max_run) max_run = run;
    if (hsync_out) hs_cnt++;
    if (!in_ready) rdy_low_seen = 1'b1;
  endtask

  task automatic push(input logic [2*HW-1:0] d, input logic h, input logic v, input logic f);
    int g = 0;
    data_in = d; hsync_in = h; vsync_in = v; fsync_in = f; in_valid = 1'b1;
    while (!in_ready && g < 20) begin
      cycle();
      g++;
    end
    check("push_ready_timeout", (g < 20), 1);
    cycle();
    in_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; fsync_in = 1'b0;
  endtask

  initial begin
    int  i, guard;
    bit  accept, uflag, seen;

    // Reset held for 3 edges: everything low
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready,  0);
      check("rst_data_out",  data_out,  0);
      check("rst_phase",     phase,     0);
      check("rst_underrun",  underrun,  0);
      check("rst_syncs",     {hsync_out, vsync_out, fsync_out}, 0);
    end
    rst = 1'b0;
    cycle();
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // Single word: low half after k+1, high half after k+2, underrun after k+3
    data_in = 20'hABC55; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("sw_no_early_out", out_valid, 0);
    cycle();
    check("sw_low_data",  data_out, 10'h055);
    check("sw_low_phase", phase, 0);
    check("sw_low_valid", out_valid, 1);
    cycle();
    check("sw_high_data",  data_out, 10'h2AF);
    check("sw_high_phase", phase, 1);
    check("sw_high_under", underrun, 0);
    cycle();
    check("sw_idle_valid", out_valid, 0);
    check("sw_underrun",   underrun, 1);
`ifdef VSS_UNDERRUN_BLANK_EN
    check("blank_c0", data_out, 10'h200);
    cycle();
    check("blank_y",  data_out, 10'h040);
    check("blank_valid", out_valid, 0);
    cycle();
    check("blank_c1", data_out, 10'h200);
    check("blank_valid2", out_valid, 0);
`else
    check("sw_idle_hold", data_out, 10'h2AF);
    check("sw_idle_phase", phase, 0);
`endif

    // Back-to-back stream of 8 words after a fresh reset
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    max_run = 0; run = 0; rdy_low_seen = 1'b0;
    i = 1; guard = 0;
    while (i <= 8 && guard < 100) begin
      data_in = {10'(i + 256), 10'(i)};
      in_valid = 1'b1;
      accept = in_ready;
      cycle();
      if (accept) i++;
      guard++;
    end
    in_valid = 1'b0;
    check("stream_all_accepted", i, 9);
    uflag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) uflag = uflag | underrun;
      cycle();
    end
    check("stream_run16", max_run, 16);
    check("stream_ready_dips", rdy_low_seen, 1);
    check("stream_no_underrun", uflag, 0);
    check("stream_end_underrun", underrun, 1);

    // Sync alignment: hsync high only for the two cycles of the first word
    hs_cnt = 0;
    push(20'h12345, 1'b1, 1'b0, 1'b1);
    push(20'h6789A, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cycle();
    check("sync_hsync_cycles", hs_cnt, 2);
    check("sync_vsync_last", vsync_out, 1);

    // Reset in the LOW cycle of a word with a second word queued
    data_in = 20'h3FF00; in_valid = 1'b1;
    cycle();
    data_in = 20'h0F0F0;
    cycle();
    in_valid = 1'b0;
    check("mid_low_valid", out_valid, 1);
    check("mid_low_phase", phase, 0);
    check("mid_low_data", data_out, 10'h300);
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data",  data_out, 0);
    check("mid_rst_phase", phase, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (out_valid) seen = 1'b1;
    end
    check("mid_fifo_empty", seen, 0);
    check("mid_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
